// File: rtl/alu_issue_ctrl.sv
// Issue controller for a power-gated ALU: powers the ALU up on demand, issues one
// operation at a time, returns the result and powers down after idling or a hang.
module alu_issue_ctrl #(
    parameter int IDLE_TIMEOUT = 16,
    parameter int PWRUP_CYCLES = 4,
    parameter int BUSY_MAX     = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_start,
    input  logic        alu_busy,
    input  logic [15:0] alu_result,
    output logic        alu_pwr_en,
    output logic        iso_en,
    output logic [2:0]  dbg_state_o
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int PW = $clog2(PWRUP_CYCLES + 1);
    localparam int BW = $clog2(BUSY_MAX + 1);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        PWRUP   = 3'd1,
        IDLE    = 3'd2,
        ISSUE   = 3'd3,
        WAIT    = 3'd4,
        RESP    = 3'd5,
        ISOLATE = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [PW-1:0] pu_cnt_q, pu_cnt_d;
    logic [BW-1:0] wd_cnt_q, wd_cnt_d;
    logic        force_pd_q, force_pd_d;
    logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_valid_q, alu_start_q, pwr_en_q, iso_en_q;

    // Handshakes: a transfer happens at a rising clk edge where valid && ready.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        pu_cnt_d   = pu_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        force_pd_d = force_pd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            OFF: begin
                if (req_valid) begin
                    state_d  = PWRUP;
                    pu_cnt_d = '0;
                end
            end
            PWRUP: begin
                if (pu_cnt_q == PW'(PWRUP_CYCLES - 1)) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    pu_cnt_d = pu_cnt_q + PW'(1);
                end
            end
            IDLE: begin
                // Acceptance is checked first so it wins over a same-cycle timeout.
                if (req_valid) begin
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    alu_op_d   = req_op;
                    idle_cnt_d = '0;
                    if (req_op >= 4'b1010) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
                    state_d = ISOLATE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                wd_cnt_d = '0;
            end
            WAIT: begin
                if (!alu_busy) begin
                    state_d    = RESP;
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                end else if (wd_cnt_q == BW'(BUSY_MAX - 1)) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    force_pd_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + BW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    force_pd_d = 1'b0;
                    if (force_pd_q) begin
                        state_d = ISOLATE;
                    end else begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end
                end
            end
            ISOLATE: state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OFF;
            idle_cnt_q  <= '0;
            pu_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            force_pd_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_start_q <= 1'b0;
            pwr_en_q    <= 1'b0;
            iso_en_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            pu_cnt_q    <= pu_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            force_pd_q  <= force_pd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            // Registered outputs are decoded from the next state so they align with it.
            rsp_valid_q <= (state_d == RESP);
            alu_start_q <= (state_d == ISSUE);
            pwr_en_q    <= (state_d != OFF);
            iso_en_q    <= (state_d == OFF) || (state_d == PWRUP) || (state_d == ISOLATE);
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign alu_start   = alu_start_q;
    assign alu_pwr_en  = pwr_en_q;
    assign iso_en      = iso_en_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU model
// (MUL busy for 5 WAIT cycles, DIV for 9, others respond immediately).
module tb_alu_issue_ctrl;
    localparam logic [2:0] S_OFF = 3'd0, S_PWRUP = 3'd1, S_IDLE = 3'd2, S_ISSUE = 3'd3,
                           S_WAIT = 3'd4, S_RESP = 3'd5, S_ISOLATE = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_op = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_data, alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_start, alu_busy, alu_pwr_en, iso_en;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [3:0] busy_cnt = '0;
    logic       force_busy = 1'b0;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_start(alu_start), .alu_busy(alu_busy), .alu_result(alu_result),
        .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_start)
            busy_cnt <= (alu_opcode == 4'd8) ? 4'd5 : (alu_opcode == 4'd9) ? 4'd9 : 4'd0;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 4'd1;
    end
    assign alu_busy = force_busy || (busy_cnt != 0);

    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd8: alu_result = alu_a * alu_b;
            4'd9: alu_result = (alu_b != 0) ? alu_a / alu_b : 16'hffff;
            default: alu_result = '0;
        endcase
    end

    // Called at #1 after an edge; issues one request, checks latency, result and handshake.
    task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input logic exp_err, input int exp_lat, input int hold);
        bit acc;
        bit rdy;
        int lat;
        int starts;
        int bad_opnd;
        int bad_pwr;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) acc = 1;
            #1;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s_accept: never accepted (required acceptance within 100 cycles)", name);
            return;
        end
        lat = 0; starts = 0; bad_opnd = 0; bad_pwr = 0;
        while (!rsp_valid && lat < 64) begin
            if (alu_start) starts++;
            if (alu_a !== a || alu_b !== b || alu_opcode !== op) bad_opnd++;
            if (iso_en !== 1'b0 || alu_pwr_en !== 1'b1) bad_pwr++;
            @(posedge clk); #1;
            lat++;
        end
        if (alu_start) starts++;
        n_cmp++;
        if (exp_lat >= 0 && lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (rsp_data !== exp_data || rsp_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_rsp: data=%0d err=%0b, required data=%0d err=%0b",
                     name, rsp_data, rsp_err, exp_data, exp_err);
        end
        n_cmp++;
        if (starts !== ((op >= 4'b1010) ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s_start: alu_start high %0d cycles, required %0d",
                     name, starts, (op >= 4'b1010) ? 0 : 1);
        end
        n_cmp++;
        if (bad_opnd != 0 || bad_pwr != 0) begin
            n_fail++;
            $display("FAIL %s_stable: %0d operand and %0d power glitches, required 0",
                     name, bad_opnd, bad_pwr);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold%0d: valid=%0b data=%0d ready=%0b, required 1/%0d/0",
                         name, i, rsp_valid, rsp_data, req_ready, exp_data);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_handshake: rsp_valid=%0b after handshake, required 0", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dbg_state !== S_OFF || alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || alu_start !== 1'b0 ||
            req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 16'd0 ||
            alu_a !== 16'd0 || alu_b !== 16'd0 || alu_opcode !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: st=%0d pwr=%0b iso=%0b start=%0b rdy=%0b vld=%0b, required 0/0/1/0/0/0",
                     dbg_state, alu_pwr_en, iso_en, alu_start, req_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_powerup();
        int n;
        req_op = 4'd0; req_a = 16'd3; req_b = 16'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (dbg_state !== S_PWRUP || alu_pwr_en !== 1'b1 || iso_en !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pwrup_enter: st=%0d pwr=%0b iso=%0b rdy=%0b, required 1/1/1/0",
                     dbg_state, alu_pwr_en, iso_en, req_ready);
        end
        n = 0;
        while (iso_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n !== 4 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pwrup_len: iso_en fell after %0d cycles rdy=%0b, required 4 and 1", n, req_ready);
        end
        do_op("add", 4'd0, 16'd3, 16'd5, 16'd8, 1'b0, 2, 0);
    endtask

    task automatic test_ops();
        do_op("sub", 4'd1, 16'd10, 16'd3, 16'd7, 1'b0, 2, 0);
        do_op("mul", 4'd8, 16'd300, 16'd7, 16'd2100, 1'b0, 7, 0);
        do_op("div", 4'd9, 16'd100, 16'd7, 16'd14, 1'b0, 11, 0);
    endtask

    task automatic test_illegal();
        do_op("ill_1011", 4'b1011, 16'd9, 16'd9, 16'd0, 1'b1, -1, 0);
        do_op("ill_1111", 4'b1111, 16'd1, 16'd2, 16'd0, 1'b1, -1, 0);
    endtask

    task automatic test_backpressure();
        do_op("hold", 4'd0, 16'd40, 16'd2, 16'd42, 1'b0, 2, 5);
    endtask

    task automatic test_back_to_back();
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL timeout_edge_state: st=%0d, required %0d", dbg_state, S_IDLE);
        end
        do_op("timeout_accept", 4'd0, 16'd100, 16'd23, 16'd123, 1'b0, 2, 0);
    endtask

    task automatic test_idle_timeout();
        int n;
        n = 0;
        while (!iso_en && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n !== 16 || alu_pwr_en !== 1'b1 || dbg_state !== S_ISOLATE) begin
            n_fail++;
            $display("FAIL idle_iso: iso rose after %0d pwr=%0b st=%0d, required 16/1/%0d",
                     n, alu_pwr_en, dbg_state, S_ISOLATE);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || dbg_state !== S_OFF) begin
            n_fail++;
            $display("FAIL idle_off: pwr=%0b iso=%0b st=%0d, required 0/1/%0d",
                     alu_pwr_en, iso_en, dbg_state, S_OFF);
        end
    endtask

    task automatic test_watchdog();
        force_busy = 1'b1;
        do_op("watchdog", 4'd0, 16'd1, 16'd1, 16'd0, 1'b1, 32, 0);
        force_busy = 1'b0;
        n_cmp++;
        if (dbg_state !== S_ISOLATE || iso_en !== 1'b1 || alu_pwr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_isolate: st=%0d iso=%0b pwr=%0b, required %0d/1/1",
                     dbg_state, iso_en, alu_pwr_en, S_ISOLATE);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (dbg_state !== S_OFF || alu_pwr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_off: st=%0d pwr=%0b, required %0d/0", dbg_state, alu_pwr_en, S_OFF);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        int guard;
        req_op = 4'd8; req_a = 16'd300; req_b = 16'd7; req_valid = 1'b1;
        guard = 0;
        while (dbg_state !== S_ISSUE && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dbg_state !== S_WAIT) begin
            n_fail++;
            $display("FAIL rst_pre_wait: st=%0d, required %0d", dbg_state, S_WAIT);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dbg_state !== S_OFF || iso_en !== 1'b1 || alu_pwr_en !== 1'b0 || rsp_valid !== 1'b0 ||
            alu_a !== 16'd0 || alu_opcode !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: st=%0d iso=%0b pwr=%0b vld=%0b a=%0d, required %0d/1/0/0/0",
                     dbg_state, iso_en, alu_pwr_en, rsp_valid, alu_a, S_OFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || dbg_state !== S_OFF) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_rsp: %0d cycles with response or leaving OFF, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_ops();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_idle_timeout();
        test_watchdog();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
